shift_register_univ: RTL and testbench

//  Parametrised universal shift register: WIDTH-bit, async active-low reset.

---
 rtl/shift_register_univ_if.sv | 31 +++
 rtl/shift_register_univ.sv | 128 ++++++++++++
 tb/tb_shift_register_univ.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/shift_register_univ_if.sv
// Signal bundle for shift_register_univ: mode/data/burst controls in, register
// contents and burst status out. The slave modport is the register side.
interface shift_register_univ_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic [1:0]       MODE;
    logic             ROT;
    logic             SIR;
    logic             SIL;
    logic [WIDTH-1:0] D;
    logic             GO;
    logic [CNT_W-1:0] CNT;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic             BUSY;
    logic             DONE;
    logic [15:0]      TOGGLES;
    logic             STATE_DBG;

    modport master (
        output MODE, ROT, SIR, SIL, D, GO, CNT,
        input  Q, SOR, SOL, BUSY, DONE, TOGGLES, STATE_DBG
    );

    modport slave (
        input  MODE, ROT, SIR, SIL, D, GO, CNT,
        output Q, SOR, SOL, BUSY, DONE, TOGGLES, STATE_DBG
    );
endinterface

// File: rtl/shift_register_univ.sv
// Universal shift register (hold / shift right / shift left / load, optional rotate)
// with a GO/CNT burst shift. Define SHIFT_REG_TOGGLE_CNT_EN to build the TOGGLES counter.
module shift_register_univ #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    shift_register_univ_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q;
    logic             dir_left_q;
    logic             rot_q;
    logic             done_q;

    logic             mode_shr, mode_shl, mode_ld;
    logic             go_shift;
    logic [WIDTH-1:0] shr_live, shl_live, shr_burst, shl_burst;

    // Any MODE value not matching a defined encoding (including X/Z) falls to hold.
    always_comb begin
        mode_shr = 1'b0;
        mode_shl = 1'b0;
        mode_ld  = 1'b0;
        case (bus.MODE)
            2'b01:   mode_shr = 1'b1;
            2'b10:   mode_shl = 1'b1;
            2'b11:   mode_ld  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        shr_live  = {bus.ROT ? q_q[0] : bus.SIR, q_q[WIDTH-1:1]};
        shl_live  = {q_q[WIDTH-2:0], bus.ROT ? q_q[WIDTH-1] : bus.SIL};
        shr_burst = {rot_q ? q_q[0] : bus.SIR, q_q[WIDTH-1:1]};
        shl_burst = {q_q[WIDTH-2:0], rot_q ? q_q[WIDTH-1] : bus.SIL};
        go_shift  = bus.GO && (mode_shr || mode_shl);
    end

    always_comb begin
        q_d = q_q;
        if (state_q == BURST) begin
            q_d = dir_left_q ? shl_burst : shr_burst;
        end else if (go_shift && (bus.CNT == '0)) begin
            q_d = q_q;
        end else if (mode_shr) begin
            q_d = shr_live;
        end else if (mode_shl) begin
            q_d = shl_live;
        end else if (mode_ld) begin
            q_d = bus.D;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            q_q        <= '0;
            rem_q      <= '0;
            dir_left_q <= 1'b0;
            rot_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            q_q    <= q_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_shift) begin
                        if (bus.CNT == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            dir_left_q <= mode_shl;
                            rot_q      <= bus.ROT;
                            rem_q      <= bus.CNT - 1'b1;
                            if (bus.CNT == CNT_W'(1)) done_q  <= 1'b1;
                            else                      state_q <= BURST;
                        end
                    end
                end
                BURST: begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Q         = q_q;
    assign bus.SOR       = q_q[0];
    assign bus.SOL       = q_q[WIDTH-1];
    assign bus.BUSY      = (state_q == BURST);
    assign bus.DONE      = done_q;
    assign bus.STATE_DBG = state_q;

`ifdef SHIFT_REG_TOGGLE_CNT_EN
    logic [15:0]      tog_q;
    logic [WIDTH-1:0] rise;
    logic [16:0]      rise_cnt, tog_sum;

    // Counts bits rising on the same edge that updates Q.
    always_comb begin
        rise     = q_d & ~q_q;
        rise_cnt = '0;
        for (int i = 0; i < WIDTH; i++) rise_cnt = rise_cnt + 17'(rise[i]);
        tog_sum = {1'b0, tog_q} + rise_cnt;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) tog_q <= '0;
        else        tog_q <= tog_sum[16] ? 16'hFFFF : tog_sum[15:0];
    end

    assign bus.TOGGLES = tog_q;
`else
    assign bus.TOGGLES = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ: table of single-edge operations plus
// hand-written burst, reset and toggle-count sequences.
module tb_shift_register_univ;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    shift_register_univ_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_register_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]       mode;
        logic             rot;
        logic             sir;
        logic             sil;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic rot, input logic sir,
                         input logic sil, input logic [WIDTH-1:0] d,
                         input logic go, input logic [CNT_W-1:0] cnt);
        bus.MODE = mode;
        bus.ROT  = rot;
        bus.SIR  = sir;
        bus.SIL  = sil;
        bus.D    = d;
        bus.GO   = go;
        bus.CNT  = cnt;
    endtask

    task automatic check_out(input string name, input logic [WIDTH-1:0] q,
                             input logic busy, input logic done);
        check({name, ".q"},    32'(bus.Q),    32'(q));
        check({name, ".busy"}, 32'(bus.BUSY), 32'(busy));
        check({name, ".done"}, 32'(bus.DONE), 32'(done));
    endtask

    int done_seen;

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        vecs[0]  = '{2'b11, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA};
        vecs[1]  = '{2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 4'hD};
        vecs[2]  = '{2'b11, 1'b0, 1'b0, 1'b0, 4'h9, 4'h9};
        vecs[3]  = '{2'b10, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 1'b1, 4'hF, 4'h3};
        vecs[5]  = '{2'b01, 1'b1, 1'b0, 1'b0, 4'h0, 4'h9};
        vecs[6]  = '{2'b10, 1'b0, 1'b0, 1'b1, 4'h0, 4'h3};
        vecs[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1};
        vecs[8]  = '{2'b10, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF};
        vecs[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7};
        vecs[11] = '{2'b10, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE};

        #12;
        check_out("reset", 4'h0, 1'b0, 1'b0);
        check("reset.toggles", 32'(bus.TOGGLES), 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Single-edge operations, state carried from one vector to the next.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mode, vecs[i].rot, vecs[i].sir, vecs[i].sil, vecs[i].d, 1'b0, '0);
            @(negedge CLK);
            check($sformatf("vec%0d.q", i),   32'(bus.Q),   32'(vecs[i].exp_q));
            check($sformatf("vec%0d.sor", i), 32'(bus.SOR), 32'(vecs[i].exp_q[0]));
            check($sformatf("vec%0d.sol", i), 32'(bus.SOL), 32'(vecs[i].exp_q[WIDTH-1]));
            check($sformatf("vec%0d.busy", i), 32'(bus.BUSY), 32'h0);
        end

        // Unknown MODE holds.
        bus.MODE = 2'bxx;
        @(negedge CLK);
        check("xmode.q", 32'(bus.Q), 32'hE);

        // Asynchronous reset mid-cycle with Q=F.
        drive(2'b11, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, '0);
        @(negedge CLK);
        check("preload_f.q", 32'(bus.Q), 32'hF);
        drive(2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #2 RESET = 1'b0;
        #1;
        check_out("async_reset", 4'h0, 1'b0, 1'b0);
        @(negedge CLK);
        check("async_reset_hold.q", 32'(bus.Q), 32'h0);
        RESET = 1'b1;

        // Burst left by 3 from Q=1; MODE/D/GO during BUSY are ignored.
        drive(2'b11, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, '0);
        @(negedge CLK);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd3);
        @(negedge CLK);
        check_out("burst3.e1", 4'h2, 1'b1, 1'b0);
        check("burst3.state", 32'(bus.STATE_DBG), 32'h1);
        drive(2'b11, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 3'd7);
        @(negedge CLK);
        check_out("burst3.e2", 4'h4, 1'b1, 1'b0);
        bus.GO = 1'b0;
        @(negedge CLK);
        check_out("burst3.e3", 4'h8, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        check_out("burst3.after", 4'h8, 1'b0, 1'b0);

        // CNT=0 burst: no shift, DONE only.
        drive(2'b01, 1'b0, 1'b1, 1'b0, '0, 1'b1, 3'd0);
        @(negedge CLK);
        check_out("cnt0", 4'h8, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        check_out("cnt0.after", 4'h8, 1'b0, 1'b0);

        // CNT=1 rotate right, then a second burst accepted in the DONE cycle.
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 1'b1, 3'd1);
        @(negedge CLK);
        check_out("cnt1", 4'h4, 1'b0, 1'b1);
        drive(2'b01, 1'b0, 1'b1, 1'b0, '0, 1'b1, 3'd2);
        @(negedge CLK);
        check_out("b2b.e1", 4'hA, 1'b1, 1'b0);
        drive(2'b10, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0);
        @(negedge CLK);
        check_out("b2b.e2", 4'h5, 1'b0, 1'b1);

        // Reset during a CNT=5 burst: no DONE may ever appear.
        drive(2'b01, 1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd5);
        @(negedge CLK);
        check_out("abort.e1", 4'h2, 1'b1, 1'b0);
        bus.GO = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check_out("abort.reset", 4'h0, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 2) RESET = 1'b1;
            if (bus.DONE !== 1'b0) done_seen++;
        end
        check("abort.done_pulses", 32'(done_seen), 32'h0);
        check_out("abort.final", 4'h0, 1'b0, 1'b0);

        // Rising-bit counter, cleared by the reset above.
        drive(2'b11, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, '0);
        @(negedge CLK);
`ifdef SHIFT_REG_TOGGLE_CNT_EN
        check("toggles.load_f", 32'(bus.TOGGLES), 32'd4);
`else
        check("toggles.load_f", 32'(bus.TOGGLES), 32'd0);
`endif
        bus.D = 4'h0;
        @(negedge CLK);
        bus.D = 4'h5;
        @(negedge CLK);
        check("toggles.q5", 32'(bus.Q), 32'h5);
`ifdef SHIFT_REG_TOGGLE_CNT_EN
        check("toggles.load_5", 32'(bus.TOGGLES), 32'd6);
`else
        check("toggles.load_5", 32'(bus.TOGGLES), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
